// File: rtl/stream_word_sink_if.sv
// stream_word_sink_if: valid/ready word stream carrying a data word and a sequence tag.
interface stream_word_sink_if #(
  parameter int DATA_W = 22,
  parameter int TAG_W  = 2
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag;
  modport master (output valid, data, tag, input ready);
  modport slave  (input valid, data, tag, output ready);
endinterface

// File: rtl/stream_word_sink.sv
// stream_word_sink: buffers a tagged word stream in a small FIFO, checks tag continuity,
// and keeps a saturating word count plus a wrapping checksum of accepted data.
module stream_word_sink #(
  parameter int DATA_W = 22,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  stream_word_sink_if.slave  in_if,
  stream_word_sink_if.master out_if,
  output logic              err_seq_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [DATA_W-1:0] checksum_o,
  output logic [1:0]        state_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, ERROR = 2'b10} state_t;
  logic [DATA_W+TAG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              rdy_q, acc, pop;
  state_t            st_q, st_d;
  logic [TAG_W-1:0]  exp_q, exp_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic [DATA_W-1:0] cs_q, cs_d;
  assign acc = in_if.valid & rdy_q;
  assign pop = out_if.valid & out_if.ready;
  assign cnt_d = cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
  assign in_if.ready = rdy_q;
  assign out_if.valid = cnt_q != '0;
  assign {out_if.tag, out_if.data} = mem_q[rd_q];
  assign err_seq_o = err_q;
  assign word_cnt_o = wc_q;
  assign checksum_o = cs_q;
  assign state_o = st_q;
  // clr wins over a same-cycle accept: the word is still buffered, just not counted
  always_comb begin
    st_d  = st_q;
    exp_d = exp_q;
    err_d = err_q;
    wc_d  = wc_q;
    cs_d  = cs_q;
    if (clr_i) begin
      st_d  = IDLE;
      err_d = 1'b0;
      wc_d  = '0;
      cs_d  = '0;
    end else if (acc) begin
      wc_d  = &wc_q ? wc_q : wc_q + CNT_W'(1);
      cs_d  = cs_q + in_if.data;
      exp_d = in_if.tag + TAG_W'(1);
      st_d  = st_q == IDLE ? ACTIVE : (st_q == ACTIVE && in_if.tag != exp_q) ? ERROR : st_q;
      err_d = err_q | (st_q == ACTIVE && in_if.tag != exp_q);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      st_q  <= IDLE;
      exp_q <= '0;
      err_q <= 1'b0;
      wc_q  <= '0;
      cs_q  <= '0;
    end else begin
      if (acc) mem_q[wr_q] <= {in_if.tag, in_if.data};
      wr_q  <= wr_q + AW'(acc);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != (AW+1)'(DEPTH);
      st_q  <= st_d;
      exp_q <= exp_d;
      err_q <= err_d;
      wc_q  <= wc_d;
      cs_q  <= cs_d;
    end
  end
endmodule

// File: tb/tb_stream_word_sink.sv
// tb_stream_word_sink: scoreboard bench; accepted words are queued and checked as they leave the FIFO.
module tb_stream_word_sink;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        err_seq;
  logic [15:0] word_cnt;
  logic [21:0] checksum;
  logic [1:0]  state;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] sb [$];
  stream_word_sink_if #(.DATA_W(22), .TAG_W(2)) in_if ();
  stream_word_sink_if #(.DATA_W(22), .TAG_W(2)) out_if ();
  stream_word_sink dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_if(in_if), .out_if(out_if),
    .err_seq_o(err_seq), .word_cnt_o(word_cnt), .checksum_o(checksum), .state_o(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_if.valid && out_if.ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("out_word", {8'h0, out_if.tag, out_if.data}, {8'h0, sb.pop_front()});
    end
    if (in_if.valid && in_if.ready) sb.push_back({in_if.tag, in_if.data});
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [21:0] d, input logic [1:0] t);
    logic acc;
    int n = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.tag   = t;
    do begin
      acc = in_if.ready;
      cyc(1);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'(acc), 1);
    in_if.valid = 1'b0;
  endtask
  task automatic clr_pulse();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask
  initial begin
    in_if.valid = 1'b0;
    in_if.data = '0;
    in_if.tag = '0;
    out_if.ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_if.ready), 0);
    chk("rst_out_valid", 32'(out_if.valid), 0);
    chk("rst_out_data", 32'(out_if.data), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_checksum", 32'(checksum), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_err", 32'(err_seq), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_in_ready", 32'(in_if.ready), 1);
    for (int i = 0; i < 5; i++) send(22'(i + 1), 2'(i));
    cyc(3);
    chk("t1_word_cnt", 32'(word_cnt), 5);
    chk("t1_checksum", 32'(checksum), 15);
    chk("t1_err", 32'(err_seq), 0);
    chk("t1_state", 32'(state), 1);
    chk("t1_drained", 32'(sb.size()), 0);
    clr_pulse();
    out_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) send(22'(100 + i), 2'(i));
    chk("t2_full_ready", 32'(in_if.ready), 0);
    chk("t2_head", 32'(out_if.data), 100);
    in_if.valid = 1'b1;
    in_if.data = 22'd104;
    in_if.tag = 2'd0;
    cyc(1);
    chk("t2_blocked", 32'(in_if.ready), 0);
    out_if.ready = 1'b1;
    cyc(1);
    out_if.ready = 1'b0;
    chk("t5_no_bypass_ready", 32'(in_if.ready), 1);
    chk("t5_no_bypass_cnt", 32'(word_cnt), 4);
    cyc(1);
    in_if.valid = 1'b0;
    chk("t5_refull_ready", 32'(in_if.ready), 0);
    chk("t5_refull_cnt", 32'(word_cnt), 5);
    out_if.ready = 1'b1;
    cyc(6);
    chk("t2_drained", 32'(sb.size()), 0);
    chk("t2_err", 32'(err_seq), 0);
    clr_pulse();
    chk("t3_clr_state", 32'(state), 0);
    send(22'd10, 2'd0);
    send(22'd11, 2'd1);
    chk("t3_active", 32'(state), 1);
    send(22'd12, 2'd3);
    chk("t3_err", 32'(err_seq), 1);
    chk("t3_state_err", 32'(state), 2);
    send(22'd13, 2'd0);
    chk("t3_err_sticky", 32'(err_seq), 1);
    chk("t3_state_stay", 32'(state), 2);
    chk("t3_word_cnt", 32'(word_cnt), 4);
    clr_pulse();
    chk("t3_clr_err", 32'(err_seq), 0);
    chk("t3_clr_state2", 32'(state), 0);
    chk("t3_clr_cnt", 32'(word_cnt), 0);
    send(22'h3FFFFF, 2'd1);
    send(22'h000002, 2'd2);
    chk("t4_checksum_wrap", 32'(checksum), 1);
    chk("t4_word_cnt", 32'(word_cnt), 2);
    in_if.valid = 1'b1;
    in_if.data = 22'h55;
    in_if.tag = 2'd3;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    in_if.valid = 1'b0;
    chk("clr_acc_cnt", 32'(word_cnt), 0);
    chk("clr_acc_sum", 32'(checksum), 0);
    cyc(3);
    chk("clr_acc_drained", 32'(sb.size()), 0);
    out_if.ready = 1'b0;
    send(22'd7, 2'd0);
    send(22'd8, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_if.valid), 0);
    chk("t6_word_cnt", 32'(word_cnt), 0);
    chk("t6_state", 32'(state), 0);
    chk("t6_in_ready", 32'(in_if.ready), 0);
    sb.delete();
    cyc(1);
    rst_n = 1'b1;
    out_if.ready = 1'b1;
    cyc(1);
    chk("t6_ready_back", 32'(in_if.ready), 1);
    send(22'd9, 2'd2);
    cyc(3);
    chk("t6_drained", 32'(sb.size()), 0);
    chk("t6_word_cnt2", 32'(word_cnt), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
